// File: rtl/prga_decrypt_fsm.sv
// RC4 PRGA decrypt engine.
// Reads the shuffled S memory, generates one keystream byte per message byte,
// XORs it with the encrypted ROM byte and writes the plaintext to the RAM.
// Optionally stops early on the first byte that is not a lowercase letter
// or a space, clearing key_valid so the key search can skip this candidate.
module prga_decrypt_fsm #(
  parameter int MSG_LEN     = 32,
  parameter int MSG_AW      = 5,
  parameter bit CHECK_CHARS = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [MSG_AW-1:0] ram_address,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic              busy,
  output logic              done,
  output logic              key_valid
);

  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, LT_I, RD_J, WT_J, LT_J,
    SW_I, SW_J, RD_F, WT_F, LT_F, WR_O, DONE
  } state_t;

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  state_t state, state_nxt;

  logic [7:0]        i, j, si, sj, f, enc;
  logic [MSG_AW-1:0] k;

  // Bus hold registers: each bus keeps its last driven value while unused.
  logic [7:0]        s_address_q, s_data_q, ram_data_q;
  logic [MSG_AW-1:0] rom_address_q, ram_address_q;

  logic [7:0] plain;
  logic       plain_ok;
  logic       last_byte;

  assign plain     = f ^ enc;
  assign plain_ok  = ((plain >= 8'h61) && (plain <= 8'h7A)) || (plain == 8'h20);
  assign last_byte = (k == K_LAST);
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

  // State register; reset drops straight back to IDLE.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and memory-port drive for each step of the byte loop.
  always_comb begin
    state_nxt   = state;
    s_address   = s_address_q;
    s_data      = s_data_q;
    s_wren      = 1'b0;
    rom_address = rom_address_q;
    ram_address = ram_address_q;
    ram_data    = ram_data_q;
    ram_wren    = 1'b0;
    unique case (state)
      IDLE, DONE: if (start) state_nxt = RD_I;
      RD_I: begin
        s_address = i;
        state_nxt = WT_I;
      end
      WT_I: state_nxt = LT_I;
      LT_I: state_nxt = RD_J;
      RD_J: begin
        s_address = j;
        state_nxt = WT_J;
      end
      WT_J: state_nxt = LT_J;
      LT_J: state_nxt = SW_I;
      SW_I: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
        state_nxt = SW_J;
      end
      SW_J: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
        state_nxt = RD_F;
      end
      RD_F: begin
        s_address   = si + sj;
        rom_address = k;
        state_nxt   = WT_F;
      end
      WT_F: state_nxt = LT_F;
      LT_F: state_nxt = WR_O;
      WR_O: begin
        ram_address = k;
        ram_data    = plain;
        ram_wren    = 1'b1;
        if (CHECK_CHARS && !plain_ok) state_nxt = DONE;
        else if (last_byte)           state_nxt = DONE;
        else                          state_nxt = RD_I;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture whatever each bus drove this cycle so it holds when idle.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      s_address_q   <= '0;
      s_data_q      <= '0;
      rom_address_q <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
    end else begin
      s_address_q   <= s_address;
      s_data_q      <= s_data;
      rom_address_q <= rom_address;
      ram_address_q <= ram_address;
      ram_data_q    <= ram_data;
    end
  end

  // PRGA indices, latched memory data and the running key verdict.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      i         <= '0;
      j         <= '0;
      k         <= '0;
      si        <= '0;
      sj        <= '0;
      f         <= '0;
      enc       <= '0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            i         <= 8'd1;
            j         <= 8'd0;
            k         <= '0;
            key_valid <= 1'b1;
          end
        end
        LT_I: begin
          si <= s_q;
          j  <= j + s_q;
        end
        LT_J: sj <= s_q;
        LT_F: begin
          f   <= s_q;
          enc <= rom_q;
        end
        WR_O: begin
          if (CHECK_CHARS && !plain_ok) begin
            key_valid <= 1'b0;
          end else if (!last_byte) begin
            k <= k + 1'b1;
            i <= i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
